traffic_signal_controller: RTL and testbench

Phase sequencer for the four-approach intersection. It drives the shared `Signal_Pos` and `light_out_time` buses consumed by every per-approach car-simulation block, and generates their 4 Hz blink clock `CLK_4Hz`. Green is granted round-robin to approaches with waiting cars, with minimum/maximum green time, an all-red clearance interval between greens, and emergency preemption.

---
 rtl/traffic_signal_controller_if.sv | 22 ++
 rtl/traffic_signal_controller.sv | 141 ++++++++++++++
 tb/tb_traffic_signal_controller.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_signal_controller_if.sv
// Intersection bus: request/preemption inputs to the phase sequencer and the
// shared signal-position, clearance, countdown and blink outputs it drives.
interface traffic_signal_controller_if;
    logic       Tick;
    logic [3:0] Car_req;
    logic       Emergency;
    logic [1:0] Emergency_dir;
    logic [1:0] Signal_Pos;
    logic       light_out_time;
    logic [4:0] Time_left;
    logic       CLK_4Hz;

    modport master (
        output Tick, Car_req, Emergency, Emergency_dir,
        input  Signal_Pos, light_out_time, Time_left, CLK_4Hz
    );

    modport slave (
        input  Tick, Car_req, Emergency, Emergency_dir,
        output Signal_Pos, light_out_time, Time_left, CLK_4Hz
    );
endinterface

// File: rtl/traffic_signal_controller.sv
// Four-approach phase sequencer: round-robin green to waiting approaches with
// min/max green, all-red clearance between greens, emergency preemption, and
// a free-running blink clock for the car blocks.
module traffic_signal_controller #(
    parameter int unsigned GREEN_MIN  = 5,
    parameter int unsigned GREEN_MAX  = 15,
    parameter int unsigned CLEAR_TIME = 2,
    parameter int unsigned BLINK_HALF = 6250000
) (
    input  logic                        CLK,
    input  logic                        Reset,
    traffic_signal_controller_if.slave  bus
);
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_GREEN = 1'b1;

    localparam int unsigned   BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    localparam logic [5:0] G_MIN6 = 6'(GREEN_MIN);
    localparam logic [5:0] G_MAX6 = 6'(GREEN_MAX);
    localparam logic [5:0] CLR6   = 6'(CLEAR_TIME);
    localparam logic [4:0] G_MAX5 = 5'(GREEN_MAX);
    localparam logic [4:0] CLR5   = 5'(CLEAR_TIME);

    logic [0:0]    state_q, state_d;
    logic [1:0]    signal_pos_q, signal_pos_d;
    logic          light_q, light_d;
    logic [4:0]    elapsed_q, elapsed_d;
    logic [4:0]    time_left_q, time_left_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          clk_4hz_q, clk_4hz_d;
    logic          preempt_q, preempt_d;

    logic [1:0] next_pos;
    logic [1:0] cand;
    logic       found;
    logic       contender;
    logic [5:0] elapsed_inc;
    logic [4:0] limit;

    assign contender   = |(bus.Car_req & ~(4'b0001 << signal_pos_q));
    assign elapsed_inc = {1'b0, elapsed_q} + 6'd1;

    // Next-green selection: emergency direction, else round-robin search, else pos+1
    always_comb begin
        next_pos = signal_pos_q + 2'd1;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = signal_pos_q + 2'(k);
            if (!found && bus.Car_req[cand]) begin
                next_pos = cand;
                found    = 1'b1;
            end
        end
        if (preempt_q || bus.Emergency) begin
            next_pos = bus.Emergency_dir;
        end
    end

    // Phase state machine, elapsed-tick counter and registered countdown
    always_comb begin
        state_d      = state_q;
        signal_pos_d = signal_pos_q;
        elapsed_d    = elapsed_q;
        preempt_d    = preempt_q;
        if (state_q == ST_CLEAR) begin
            if (bus.Tick) begin
                if (elapsed_inc == CLR6) begin
                    state_d      = ST_GREEN;
                    signal_pos_d = next_pos;
                    elapsed_d    = '0;
                    preempt_d    = 1'b0;
                end else begin
                    elapsed_d = elapsed_inc[4:0];
                end
            end
        end else begin
            if (bus.Emergency && (bus.Emergency_dir != signal_pos_q)) begin
                // Preemption needs no Tick and ignores minimum green
                state_d   = ST_CLEAR;
                elapsed_d = '0;
                preempt_d = 1'b1;
            end else if (bus.Emergency) begin
                if (bus.Tick) begin
                    elapsed_d = (elapsed_inc >= G_MAX6) ? G_MAX5 : elapsed_inc[4:0];
                end
            end else if (bus.Tick) begin
                if (((elapsed_inc >= G_MIN6) && contender) || (elapsed_inc >= G_MAX6)) begin
                    state_d   = ST_CLEAR;
                    elapsed_d = '0;
                end else begin
                    elapsed_d = elapsed_inc[4:0];
                end
            end
        end
        light_d     = (state_d == ST_CLEAR);
        limit       = (state_d == ST_CLEAR) ? CLR5 : G_MAX5;
        time_left_d = (elapsed_d >= limit) ? '0 : (limit - elapsed_d);
    end

    // Blink divider: toggles the output each time the counter wraps
    always_comb begin
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            clk_4hz_d   = ~clk_4hz_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            clk_4hz_d   = clk_4hz_q;
        end
    end

    // State registers with asynchronous reset to the clearance phase
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_CLEAR;
            signal_pos_q <= 2'd3;
            light_q      <= 1'b1;
            elapsed_q    <= '0;
            time_left_q  <= CLR5;
            blink_cnt_q  <= '0;
            clk_4hz_q    <= 1'b0;
            preempt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            signal_pos_q <= signal_pos_d;
            light_q      <= light_d;
            elapsed_q    <= elapsed_d;
            time_left_q  <= time_left_d;
            blink_cnt_q  <= blink_cnt_d;
            clk_4hz_q    <= clk_4hz_d;
            preempt_q    <= preempt_d;
        end
    end

    assign bus.Signal_Pos     = signal_pos_q;
    assign bus.light_out_time = light_q;
    assign bus.Time_left      = time_left_q;
    assign bus.CLK_4Hz        = clk_4hz_q;
endmodule

// File: tb/tb_traffic_signal_controller.sv
// Self-checking bench for traffic_signal_controller: scenario tasks push
// expected phase outputs to a scoreboard and pop them as each Tick lands.
module tb_traffic_signal_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    traffic_signal_controller_if bus();

    traffic_signal_controller #(
        .GREEN_MIN (5),
        .GREEN_MAX (15),
        .CLEAR_TIME(2),
        .BLINK_HALF(4)
    ) dut (
        .CLK  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    typedef struct {
        logic       light;
        logic [1:0] pos;
        logic [4:0] tl;
    } exp_t;

    exp_t sb[$];
    logic blink_sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    function automatic exp_t mk(input logic l, input int p, input int t);
        exp_t e;
        e.light = l;
        e.pos   = 2'(p);
        e.tl    = 5'(t);
        return e;
    endfunction

    task automatic pulse_tick();
        @(negedge clk) bus.Tick = 1'b1;
        @(negedge clk) bus.Tick = 1'b0;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        bus.Tick          = 1'b0;
        bus.Emergency     = 1'b0;
        bus.Emergency_dir = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.Tick = 1'b0; bus.Car_req = 4'b0000; bus.Emergency = 1'b0; bus.Emergency_dir = 2'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if (bus.Signal_Pos !== 2'd3) begin
            tests_failed++; $display("FAIL reset_pos: got %0d expected 3", bus.Signal_Pos);
        end
        tests_run++;
        if (bus.light_out_time !== 1'b1) begin
            tests_failed++; $display("FAIL reset_light: got %0b expected 1", bus.light_out_time);
        end
        tests_run++;
        if (bus.Time_left !== 5'd2) begin
            tests_failed++; $display("FAIL reset_time_left: got %0d expected 2", bus.Time_left);
        end
        tests_run++;
        if (bus.CLK_4Hz !== 1'b0) begin
            tests_failed++; $display("FAIL reset_blink: got %0b expected 0", bus.CLK_4Hz);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_default_cycle();
        exp_t e;
        int   n;
        do_reset();
        bus.Car_req = 4'b0000;
        sb.push_back(mk(1, 3, 1));
        sb.push_back(mk(0, 0, 15));
        for (int k = 1; k <= 14; k++) sb.push_back(mk(0, 0, 15 - k));
        sb.push_back(mk(1, 0, 2));
        sb.push_back(mk(1, 0, 1));
        sb.push_back(mk(0, 1, 15));
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            pulse_tick();
            e = sb.pop_front();
            tests_run++;
            if (bus.light_out_time !== e.light || bus.Signal_Pos !== e.pos || bus.Time_left !== e.tl) begin
                tests_failed++;
                $display("FAIL default tick %0d: got light=%0b pos=%0d tl=%0d expected light=%0b pos=%0d tl=%0d",
                         i + 1, bus.light_out_time, bus.Signal_Pos, bus.Time_left, e.light, e.pos, e.tl);
            end
        end
    endtask

    task automatic test_round_robin_skip();
        exp_t e;
        int   n;
        do_reset();
        bus.Car_req = 4'b0100;
        sb.push_back(mk(1, 3, 1));
        sb.push_back(mk(0, 2, 15));
        for (int k = 1; k <= 14; k++) sb.push_back(mk(0, 2, 15 - k));
        sb.push_back(mk(1, 2, 2));
        sb.push_back(mk(1, 2, 1));
        sb.push_back(mk(0, 2, 15));
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            pulse_tick();
            e = sb.pop_front();
            tests_run++;
            if (bus.light_out_time !== e.light || bus.Signal_Pos !== e.pos || bus.Time_left !== e.tl) begin
                tests_failed++;
                $display("FAIL round_robin tick %0d: got light=%0b pos=%0d tl=%0d expected light=%0b pos=%0d tl=%0d",
                         i + 1, bus.light_out_time, bus.Signal_Pos, bus.Time_left, e.light, e.pos, e.tl);
            end
        end
    endtask

    task automatic test_min_green();
        exp_t e;
        int   n;
        do_reset();
        bus.Car_req = 4'b0011;
        sb.push_back(mk(1, 3, 1));
        sb.push_back(mk(0, 0, 15));
        for (int k = 1; k <= 4; k++) sb.push_back(mk(0, 0, 15 - k));
        sb.push_back(mk(1, 0, 2));
        sb.push_back(mk(1, 0, 1));
        sb.push_back(mk(0, 1, 15));
        for (int k = 1; k <= 4; k++) sb.push_back(mk(0, 1, 15 - k));
        sb.push_back(mk(1, 1, 2));
        sb.push_back(mk(1, 1, 1));
        sb.push_back(mk(0, 0, 15));
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            pulse_tick();
            if (i == 8) bus.Car_req = 4'b0001;
            e = sb.pop_front();
            tests_run++;
            if (bus.light_out_time !== e.light || bus.Signal_Pos !== e.pos || bus.Time_left !== e.tl) begin
                tests_failed++;
                $display("FAIL min_green tick %0d: got light=%0b pos=%0d tl=%0d expected light=%0b pos=%0d tl=%0d",
                         i + 1, bus.light_out_time, bus.Signal_Pos, bus.Time_left, e.light, e.pos, e.tl);
            end
        end
    endtask

    task automatic test_emergency();
        exp_t e;
        int   n;
        do_reset();
        bus.Car_req = 4'b0000;
        sb.push_back(mk(1, 3, 1));
        sb.push_back(mk(0, 0, 15));
        sb.push_back(mk(0, 0, 14));
        sb.push_back(mk(0, 0, 13));
        // Preemption exits on the next clock edge without any Tick
        sb.push_back(mk(1, 0, 2));
        sb.push_back(mk(1, 0, 1));
        sb.push_back(mk(0, 3, 15));
        for (int k = 1; k <= 22; k++) sb.push_back(mk(0, 3, (15 - k > 0) ? 15 - k : 0));
        sb.push_back(mk(1, 3, 2));
        sb.push_back(mk(1, 3, 1));
        sb.push_back(mk(0, 0, 15));
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            if (i == 4) begin
                bus.Emergency     = 1'b1;
                bus.Emergency_dir = 2'd3;
                @(negedge clk);
            end else begin
                if (i == 29) begin
                    bus.Emergency = 1'b0;
                    bus.Car_req   = 4'b0001;
                end
                pulse_tick();
            end
            e = sb.pop_front();
            tests_run++;
            if (bus.light_out_time !== e.light || bus.Signal_Pos !== e.pos || bus.Time_left !== e.tl) begin
                tests_failed++;
                $display("FAIL emergency step %0d: got light=%0b pos=%0d tl=%0d expected light=%0b pos=%0d tl=%0d",
                         i + 1, bus.light_out_time, bus.Signal_Pos, bus.Time_left, e.light, e.pos, e.tl);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        bus.Car_req = 4'b0100;
        sb.push_back(mk(1, 3, 1));
        sb.push_back(mk(0, 2, 15));
        for (int i = 0; i < 2; i++) begin
            pulse_tick();
            e = sb.pop_front();
            tests_run++;
            if (bus.light_out_time !== e.light || bus.Signal_Pos !== e.pos || bus.Time_left !== e.tl) begin
                tests_failed++;
                $display("FAIL async_reset_setup tick %0d: got light=%0b pos=%0d tl=%0d expected light=%0b pos=%0d tl=%0d",
                         i + 1, bus.light_out_time, bus.Signal_Pos, bus.Time_left, e.light, e.pos, e.tl);
            end
        end
        pulse_tick();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (bus.Signal_Pos !== 2'd3 || bus.light_out_time !== 1'b1 || bus.CLK_4Hz !== 1'b0 || bus.Time_left !== 5'd2) begin
            tests_failed++;
            $display("FAIL async_reset: got pos=%0d light=%0b blink=%0b tl=%0d expected pos=3 light=1 blink=0 tl=2",
                     bus.Signal_Pos, bus.light_out_time, bus.CLK_4Hz, bus.Time_left);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_blink();
        logic b;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            blink_sb.push_back(((n / 4) % 2) == 1);
            @(negedge clk);
            b = blink_sb.pop_front();
            tests_run++;
            if (bus.CLK_4Hz !== b) begin
                tests_failed++;
                $display("FAIL blink cycle %0d: got %0b expected %0b", n, bus.CLK_4Hz, b);
            end
            bus.Tick          = (n % 3 == 0);
            bus.Emergency     = 1'($urandom_range(0, 1));
            bus.Emergency_dir = 2'($urandom_range(0, 3));
            bus.Car_req       = 4'($urandom_range(0, 15));
        end
        bus.Tick      = 1'b0;
        bus.Emergency = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_default_cycle();
        test_round_robin_skip();
        test_min_green();
        test_emergency();
        test_async_reset();
        test_blink();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
